// File: rtl/sonic_pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: block geometry, sync header codes and lock states.
package sonic_pcs_pkg;

  localparam int BLOCK_W = 66;

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_CTRL = 2'b01;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Only the two transition patterns are legal headers; 00 and 11 mark misalignment.
  function automatic logic hdr_ok(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/sonic_rx_block_sync_if.sv
// PMA-word input and aligned-block output bundle of one RX lane.
interface sonic_rx_block_sync_if #(
  parameter int DATA_W  = 40,
  parameter int BLOCK_W = 66
);
  logic               rx_ready;
  logic [DATA_W-1:0]  rx_parallel_data;
  logic [BLOCK_W-1:0] block_data;
  logic               block_valid;
  logic               block_lock;
  logic               slip;
  logic [15:0]        slip_count;

  modport master (
    output rx_ready, rx_parallel_data,
    input  block_data, block_valid, block_lock, slip, slip_count
  );

  modport slave (
    input  rx_ready, rx_parallel_data,
    output block_data, block_valid, block_lock, slip, slip_count
  );
endinterface

// File: rtl/sonic_gearbox_40_66.sv
// 40-to-66 bit gearbox with single-bit slip; bit 0 of every vector is the earliest wire bit.
module sonic_gearbox_40_66
  import sonic_pcs_pkg::*;
#(
  parameter int DATA_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [DATA_W-1:0]  din,
  input  logic               slip,
  output logic [BLOCK_W-1:0] block_data,
  output logic               block_valid
);

  localparam int BUF_W  = BLOCK_W - 1;
  localparam int COMB_W = BUF_W + DATA_W;
  localparam int CNT_W  = $clog2(COMB_W + 1);

  logic [BUF_W-1:0]   fill_reg, fill_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [BLOCK_W-1:0] data_reg;
  logic               valid_reg;
  logic [COMB_W-1:0]  comb, comb_s;
  logic [CNT_W-1:0]   tot;
  logic               emit;

  always_comb begin
    comb   = {{DATA_W{1'b0}}, fill_reg} | ({{BUF_W{1'b0}}, din} << cnt_reg);
    tot    = cnt_reg + CNT_W'(DATA_W);
    comb_s = comb;
    // Dropping the oldest buffered bit shifts every later block boundary by one.
    if (slip) begin
      comb_s = comb >> 1;
      tot    = tot - CNT_W'(1);
    end
    emit = (tot >= CNT_W'(BLOCK_W));
    if (emit) begin
      fill_next = {{(BUF_W - (DATA_W - 1)){1'b0}}, comb_s[COMB_W-1:BLOCK_W]};
      cnt_next  = tot - CNT_W'(BLOCK_W);
    end else begin
      fill_next = comb_s[BUF_W-1:0];
      cnt_next  = tot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_reg  <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      fill_reg  <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      fill_reg  <= fill_next;
      cnt_reg   <= cnt_next;
      valid_reg <= emit;
      if (emit) begin
        data_reg <= comb_s[BLOCK_W-1:0];
      end
    end
  end

  assign block_data  = data_reg;
  assign block_valid = valid_reg;

endmodule

// File: rtl/sonic_rx_block_sync.sv
// Per-lane RX block aligner: gearbox plus sync-header lock FSM that slips until aligned.
module sonic_rx_block_sync
  import sonic_pcs_pkg::*;
#(
  parameter int DATA_W     = 40,
  parameter int LOCK_CNT   = 64,
  parameter int BAD_SH_MAX = 16
) (
  input  logic                  rx_clkout,
  input  logic                  rx_clkout_reset,
  sonic_rx_block_sync_if.slave  bus
);

  localparam int SH_W  = $clog2(LOCK_CNT);
  localparam int BAD_W = $clog2(BAD_SH_MAX);

  lock_state_t        state_reg;
  logic [SH_W-1:0]    sh_cnt_reg;
  logic [BAD_W-1:0]   bad_cnt_reg;
  logic               lock_reg;
  logic [15:0]        slip_count_reg;

  logic [BLOCK_W-1:0] gb_data;
  logic               gb_valid;
  logic               hdr_good;
  logic               slip;
  logic               window_end;
  logic               bad_limit;

  sonic_gearbox_40_66 #(
    .DATA_W (DATA_W)
  ) u_gearbox (
    .clk         (rx_clkout),
    .rst         (rx_clkout_reset),
    .flush       (!bus.rx_ready),
    .din         (bus.rx_parallel_data),
    .slip        (slip),
    .block_data  (gb_data),
    .block_valid (gb_valid)
  );

  // Slip must act on the same edge that consumes the offending header.
  always_comb begin
    hdr_good   = hdr_ok(gb_data[1:0]);
    window_end = (sh_cnt_reg == SH_W'(LOCK_CNT - 1));
    bad_limit  = (bad_cnt_reg == BAD_W'(BAD_SH_MAX - 1));
    slip       = bus.rx_ready && gb_valid && !hdr_good &&
                 ((state_reg == HUNT) || bad_limit);
  end

  always_ff @(posedge rx_clkout or posedge rx_clkout_reset) begin
    if (rx_clkout_reset) begin
      state_reg      <= HUNT;
      sh_cnt_reg     <= '0;
      bad_cnt_reg    <= '0;
      lock_reg       <= 1'b0;
      slip_count_reg <= '0;
    end else begin
      if (slip) begin
        slip_count_reg <= slip_count_reg + 16'd1;
      end
      if (!bus.rx_ready) begin
        state_reg   <= HUNT;
        sh_cnt_reg  <= '0;
        bad_cnt_reg <= '0;
        lock_reg    <= 1'b0;
      end else if (gb_valid) begin
        case (state_reg)
          HUNT: begin
            if (!hdr_good) begin
              sh_cnt_reg  <= '0;
              bad_cnt_reg <= '0;
            end else if (window_end) begin
              state_reg   <= LOCKED;
              lock_reg    <= 1'b1;
              sh_cnt_reg  <= '0;
              bad_cnt_reg <= '0;
            end else begin
              sh_cnt_reg <= sh_cnt_reg + SH_W'(1);
            end
          end
          LOCKED: begin
            // A bad header that hits the limit wins over a completing window.
            if (!hdr_good && bad_limit) begin
              state_reg   <= HUNT;
              lock_reg    <= 1'b0;
              sh_cnt_reg  <= '0;
              bad_cnt_reg <= '0;
            end else if (window_end) begin
              sh_cnt_reg  <= '0;
              bad_cnt_reg <= '0;
            end else begin
              sh_cnt_reg <= sh_cnt_reg + SH_W'(1);
              if (!hdr_good) begin
                bad_cnt_reg <= bad_cnt_reg + BAD_W'(1);
              end
            end
          end
          default: begin
            state_reg <= HUNT;
            lock_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.block_data  = gb_data;
  assign bus.block_valid = gb_valid;
  assign bus.block_lock  = lock_reg;
  assign bus.slip        = slip;
  assign bus.slip_count  = slip_count_reg;

endmodule

// File: tb/tb_sonic_rx_block_sync.sv
// Bench for sonic_rx_block_sync: bit-queue transmitter and bit-queue receiver model.
module tb_sonic_rx_block_sync;
  import sonic_pcs_pkg::*;

  localparam int LOCK_N = 64;
  localparam int BAD_N  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sonic_rx_block_sync_if #(.DATA_W(40), .BLOCK_W(66)) bus ();

  sonic_rx_block_sync dut (
    .rx_clkout       (clk),
    .rx_clkout_reset (rst),
    .bus             (bus)
  );

  int checks = 0;
  int fails  = 0;

  // transmitter
  bit          txq[$];
  int          tx_idx;
  int          bad_lo[2];
  int          bad_hi[2];
  logic [63:0] lfsr;

  // receiver reference
  bit          mq[$];
  logic [65:0] m_data;
  bit          m_valid, m_lock, m_slip;
  int          m_sh, m_bad;
  logic [15:0] m_scount;

  // event trackers
  int  vseen, rise_vseen, fall_vseen, lock_rises, lock_falls;
  bit  prev_lock, slip_seen, fall_slip;
  logic [15:0] rise_scount;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_block(output logic [65:0] blk);
    logic [1:0] hdr;
    bit         bad;
    for (int i = 0; i < 64; i++)
      lfsr = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
    bad = 0;
    for (int r = 0; r < 2; r++)
      if (tx_idx >= bad_lo[r] && tx_idx <= bad_hi[r]) bad = 1;
    if (bad) hdr = $urandom_range(0, 1) ? 2'b00 : 2'b11;
    else     hdr = $urandom_range(0, 1) ? SH_DATA : SH_CTRL;
    blk = {lfsr, hdr};
    tx_idx++;
  endtask

  task automatic next_word(output logic [39:0] w);
    logic [65:0] blk;
    while (txq.size() < 40) begin
      gen_block(blk);
      for (int i = 0; i < 66; i++) txq.push_back(blk[i]);
    end
    for (int i = 0; i < 40; i++) w[i] = txq.pop_front();
  endtask

  task automatic tx_restart(input int pre_bits, input int lo0, input int hi0,
                            input int lo1, input int hi1);
    txq.delete();
    tx_idx = 0;
    bad_lo[0] = lo0; bad_hi[0] = hi0;
    bad_lo[1] = lo1; bad_hi[1] = hi1;
    for (int i = 0; i < pre_bits; i++) txq.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic model_reset();
    mq.delete();
    m_data = '0; m_valid = 0; m_lock = 0; m_sh = 0; m_bad = 0; m_scount = '0;
    vseen = 0; prev_lock = 0; lock_rises = 0; lock_falls = 0;
    rise_vseen = -1; fall_vseen = -1; fall_slip = 0; rise_scount = '1;
  endtask

  task automatic cycle(input bit rdy, input logic [39:0] w);
    bit hok;
    int nb, ns;
    bus.rx_ready         = rdy;
    bus.rx_parallel_data = w;
    hok    = (m_data[1:0] == 2'b01) || (m_data[1:0] == 2'b10);
    m_slip = rdy && m_valid && !hok && (!m_lock || m_bad == BAD_N - 1);
    @(negedge clk);
    chk("slip", 66'(bus.slip), 66'(m_slip));
    slip_seen = bus.slip;
    if (!rdy) begin
      mq.delete();
      m_data = '0; m_valid = 0; m_lock = 0; m_sh = 0; m_bad = 0;
    end else begin
      if (m_valid) begin
        if (!m_lock) begin
          if (!hok) m_sh = 0;
          else if (m_sh + 1 == LOCK_N) begin m_lock = 1; m_sh = 0; m_bad = 0; end
          else m_sh++;
        end else begin
          nb = m_bad + (hok ? 0 : 1);
          ns = m_sh + 1;
          if (nb == BAD_N) begin m_lock = 0; m_sh = 0; m_bad = 0; end
          else if (ns == LOCK_N) begin m_sh = 0; m_bad = 0; end
          else begin m_sh = ns; m_bad = nb; end
        end
      end
      for (int i = 0; i < 40; i++) mq.push_back(w[i]);
      if (m_slip) void'(mq.pop_front());
      if (mq.size() >= 66) begin
        for (int i = 0; i < 66; i++) m_data[i] = mq.pop_front();
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    if (m_slip) m_scount++;
    @(posedge clk);
    #1;
    chk("block_valid", 66'(bus.block_valid), 66'(m_valid));
    chk("block_lock", 66'(bus.block_lock), 66'(m_lock));
    chk("slip_count", 66'(bus.slip_count), 66'(m_scount));
    chk("block_data", bus.block_data, m_data);
    if (bus.block_lock && !prev_lock) begin
      lock_rises++; rise_vseen = vseen; rise_scount = bus.slip_count;
    end
    if (!bus.block_lock && prev_lock && rdy) begin
      lock_falls++; fall_vseen = vseen; fall_slip = slip_seen;
    end
    prev_lock = bus.block_lock;
    if (bus.block_valid) vseen++;
  endtask

  task automatic async_reset_mid();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 66'(bus.block_valid), 66'(0));
    chk("arst_lock", 66'(bus.block_lock), 66'(0));
    chk("arst_slip", 66'(bus.slip), 66'(0));
    chk("arst_slip_count", 66'(bus.slip_count), 66'(0));
    chk("arst_data", bus.block_data, 66'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [39:0] w;
    logic [15:0] sc;
    int          v33;
    rst = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_parallel_data = '0;
    lfsr = {$urandom, $urandom} | 64'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 66'(bus.block_valid), 66'(0));
    chk("rst_lock", 66'(bus.block_lock), 66'(0));
    chk("rst_slip_count", 66'(bus.slip_count), 66'(0));
    chk("rst_data", bus.block_data, 66'(0));
    rst = 1'b0;
    model_reset();

    // offset 0 stream; 15 bad headers in window 64..127, 16 in window 128..191
    tx_restart(0, 70, 84, 130, 145);
    next_word(w); cycle(1'b1, w);
    chk("first_word_no_valid", 66'(bus.block_valid), 66'(0));
    next_word(w); cycle(1'b1, w);
    chk("second_word_valid", 66'(bus.block_valid), 66'(1));
    v33 = 0;
    for (int c = 0; c < 300; c++) begin
      next_word(w); cycle(1'b1, w);
      if (c >= 10 && c < 43) v33 += int'(bus.block_valid);
    end
    chk("valid_per_33", 66'(v33), 66'(20));
    chk("lock_rises", 66'(lock_rises), 66'(1));
    chk("lock_on_64th_block", 66'(rise_vseen), 66'(64));
    chk("no_slips_offset0", 66'(rise_scount), 66'(0));
    chk("lock_falls", 66'(lock_falls), 66'(1));
    chk("unlock_on_146th_block", 66'(fall_vseen), 66'(146));
    chk("unlock_slip", 66'(fall_slip), 66'(1));

    // async reset mid-stream, then a stream pre-shifted by 17 bits
    async_reset_mid();
    tx_restart(17, -1, -1, -1, -1);
    for (int c = 0; c < 3000 && !bus.block_lock; c++) begin
      next_word(w); cycle(1'b1, w);
    end
    chk("lock_k17", 66'(bus.block_lock), 66'(1));
    chk("slips_k17", 66'(bus.slip_count), 66'(17));
    for (int c = 0; c < 60; c++) begin
      next_word(w); cycle(1'b1, w);
    end

    // synchronous flush while locked
    sc = bus.slip_count;
    for (int c = 0; c < 3; c++) begin
      next_word(w); cycle(1'b0, w);
      chk("flush_lock", 66'(bus.block_lock), 66'(0));
      chk("flush_valid", 66'(bus.block_valid), 66'(0));
      chk("flush_slip_count", 66'(bus.slip_count), 66'(sc));
    end
    for (int c = 0; c < 3000 && !bus.block_lock; c++) begin
      next_word(w); cycle(1'b1, w);
    end
    chk("relock", 66'(bus.block_lock), 66'(1));

    async_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
